// File: rtl/mips_dp_pkg.sv
// Shared types, opcodes and the ALU function for the multicycle MIPS datapath.
package mips_dp_pkg;

  localparam int REG_CNT = 32;
  localparam int REG_AW  = 5;

  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_RTYPE = 6'h00;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_ctl_e;

  typedef enum logic [1:0] {
    SRCB_B      = 2'b00,
    SRCB_FOUR   = 2'b01,
    SRCB_IMM    = 2'b10,
    SRCB_IMM_SH = 2'b11
  } srcb_sel_e;

  typedef enum logic [1:0] {
    PC_ALU    = 2'b00,
    PC_ALUOUT = 2'b01,
    PC_JUMP   = 2'b10,
    PC_HOLD   = 2'b11
  } pc_sel_e;

  // Add/sub wrap modulo 2^32; slt is a signed compare; unknown codes give 0.
  function automatic logic [31:0] alu_f(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic [2:0]  ctl);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    case (ctl)
      ALU_AND: alu_f = a & b;
      ALU_OR:  alu_f = a | b;
      ALU_ADD: alu_f = a + b;
      ALU_SUB: alu_f = a - b;
      ALU_SLT: alu_f = {31'b0, (sa < sb)};
      default: alu_f = '0;
    endcase
  endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32x32 register file: two combinational read ports, one synchronous write port.
// $0 reads as zero and ignores writes. Optional third read port under DP_DEBUG_PORT_EN.
module mips_regfile
  import mips_dp_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        ra1,
  input  logic [4:0]        ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we3,
  input  logic [4:0]        wa3,
  input  logic [DATA_W-1:0] wd3
`ifdef DP_DEBUG_PORT_EN
  ,
  input  logic [4:0]        dbg_ra,
  output logic [DATA_W-1:0] dbg_rd
`endif
);

  logic [DATA_W-1:0] rf [REG_CNT];

  // Clear every register on reset; otherwise write one register, never $0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < REG_CNT; i++) begin
        rf[i] <= '0;
      end
    end else if (we3 && (wa3 != '0)) begin
      rf[wa3] <= wd3;
    end
  end

  assign rd1 = (ra1 == '0) ? '0 : rf[ra1];
  assign rd2 = (ra2 == '0) ? '0 : rf[ra2];

`ifdef DP_DEBUG_PORT_EN
  assign dbg_rd = (dbg_ra == '0) ? '0 : rf[dbg_ra];
`endif

endmodule

// File: rtl/mips_multicycle_datapath.sv
// Multicycle MIPS datapath driven by an external controller's strobes.
// Holds PC, IR, MDR, A, B, ALUOut and the register file; one unified memory port.
// Optional macro DP_DEBUG_PORT_EN adds a read-only debug register-file port.
module mips_multicycle_datapath
  import mips_dp_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DATA_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pcen,
  input  logic              memwrite,
  input  logic              irwrite,
  input  logic              regwrite,
  input  logic              alusrca,
  input  logic              iord,
  input  logic              memtoreg,
  input  logic              regdst,
  input  logic [1:0]        alusrcb,
  input  logic [1:0]        pcsrc,
  input  logic [2:0]        alucontrol,
  output logic [5:0]        op,
  output logic [5:0]        funct,
  output logic              zero,
  output logic [DATA_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_wd,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rd
`ifdef DP_DEBUG_PORT_EN
  ,
  input  logic [4:0]        dbg_ra,
  output logic [DATA_W-1:0] dbg_rd
`endif
);

  logic        [DATA_W-1:0] pc;
  logic        [DATA_W-1:0] ir;
  logic        [DATA_W-1:0] mdr;
  logic        [DATA_W-1:0] a;
  logic        [DATA_W-1:0] b;
  logic        [DATA_W-1:0] aluout;
  logic        [DATA_W-1:0] rd1;
  logic        [DATA_W-1:0] rd2;
  logic        [DATA_W-1:0] wd3;
  logic        [4:0]        wa3;
  logic signed [DATA_W-1:0] signimm;
  logic        [DATA_W-1:0] srca;
  logic        [DATA_W-1:0] srcb;
  logic        [DATA_W-1:0] aluresult;
  logic        [DATA_W-1:0] pcnext;

  assign op      = ir[31:26];
  assign funct   = ir[5:0];
  assign signimm = {{16{ir[15]}}, ir[15:0]};
  assign wa3     = regdst ? ir[15:11] : ir[20:16];
  assign wd3     = memtoreg ? mdr : aluout;

  assign mem_adr = iord ? aluout : pc;
  assign mem_wd  = b;
  assign mem_we  = memwrite;

  mips_regfile #(
    .DATA_W (DATA_W)
  ) u_rf (
    .clk    (clk),
    .reset  (reset),
    .ra1    (ir[25:21]),
    .ra2    (ir[20:16]),
    .rd1    (rd1),
    .rd2    (rd2),
    .we3    (regwrite),
    .wa3    (wa3),
    .wd3    (wd3)
`ifdef DP_DEBUG_PORT_EN
    ,
    .dbg_ra (dbg_ra),
    .dbg_rd (dbg_rd)
`endif
  );

  // ALU operand selection and result; zero feeds the branch decision directly.
  always_comb begin
    srca = alusrca ? a : pc;
    case (alusrcb)
      SRCB_B:    srcb = b;
      SRCB_FOUR: srcb = 32'd4;
      SRCB_IMM:  srcb = signimm;
      default:   srcb = {signimm[29:0], 2'b00};
    endcase
    aluresult = alu_f(srca, srcb, alucontrol);
    zero      = (aluresult == '0);
  end

  // Next-PC select; the reserved code recirculates the current PC.
  always_comb begin
    case (pcsrc)
      PC_ALU:    pcnext = aluresult;
      PC_ALUOUT: pcnext = aluout;
      PC_JUMP:   pcnext = {pc[31:28], ir[25:0], 2'b00};
      default:   pcnext = pc;
    endcase
  end

  // Architectural and inter-cycle registers; reset aborts any instruction in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc     <= RESET_PC;
      ir     <= '0;
      mdr    <= '0;
      a      <= '0;
      b      <= '0;
      aluout <= '0;
    end else begin
      if (pcen) begin
        pc <= pcnext;
      end
      if (irwrite) begin
        ir <= mem_rd;
      end
      mdr    <= mem_rd;
      a      <= rd1;
      b      <= rd2;
      aluout <= aluresult;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_datapath.sv
// Directed scoreboard bench for mips_multicycle_datapath.
module tb_mips_multicycle_datapath;
  import mips_dp_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        pcen, memwrite, irwrite, regwrite;
  logic        alusrca, iord, memtoreg, regdst;
  logic [1:0]  alusrcb, pcsrc;
  logic [2:0]  alucontrol;
  logic [5:0]  op, funct;
  logic        zero;
  logic [31:0] mem_adr, mem_wd, mem_rd;
  logic        mem_we;
`ifdef DP_DEBUG_PORT_EN
  logic [4:0]  dbg_ra = 5'd0;
  logic [31:0] dbg_rd;
`endif

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];
  logic [31:0] exp_pc;
  logic [31:0] ir_m;
  logic [31:0] simm;

  mips_multicycle_datapath #(.RESET_PC(32'h0000_0000), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite),
    .regwrite(regwrite), .alusrca(alusrca), .iord(iord), .memtoreg(memtoreg),
    .regdst(regdst), .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
    .op(op), .funct(funct), .zero(zero), .mem_adr(mem_adr), .mem_wd(mem_wd),
    .mem_we(mem_we), .mem_rd(mem_rd)
`ifdef DP_DEBUG_PORT_EN
    , .dbg_ra(dbg_ra), .dbg_rd(dbg_rd)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string t, input logic [31:0] v);
    exp_q.push_back(v);
    tag_q.push_back(t);
  endtask

  task automatic chk(input logic [31:0] obs_unused_time);
    logic [31:0] e;
    string       t;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL scoreboard_empty observed=%h expected=none", obs_unused_time);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      vectors++;
      assert (obs_unused_time === e) else begin
        miscompares++;
        $error("FAIL %s observed=%h expected=%h", t, obs_unused_time, e);
      end
    end
  endtask

  task automatic idle();
    pcen = 0; memwrite = 0; irwrite = 0; regwrite = 0;
    alusrca = 0; iord = 0; memtoreg = 0; regdst = 0;
    alusrcb = 2'b00; pcsrc = 2'b00; alucontrol = 3'b000;
  endtask

  task automatic load_ir(input logic [31:0] v);
    mem_rd  = v;
    irwrite = 1;
    tick();
    irwrite = 0;
    ir_m    = v;
  endtask

  // addi $rt,$0,imm followed by the ALU and writeback cycles
  task automatic set_reg(input logic [4:0] rt, input logic [15:0] imm);
    load_ir({OP_ADDI, 5'd0, rt, imm});
    tick();
    alusrca = 1; alusrcb = 2'b10; alucontrol = ALU_ADD;
    tick();
    regwrite = 1; regdst = 0; memtoreg = 0;
    tick();
    idle();
  endtask

  logic [2:0]  ctl_tab [6];
  logic [31:0] res_tab [6];

  initial begin
    ctl_tab = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, 3'b011};
    res_tab = '{32'h0, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFF, 32'h1, 32'h0};

    idle();
    reset  = 0;
    mem_rd = 32'h0;
    exp_pc = 32'h0;
    ir_m   = 32'h0;

    // Reset held two cycles
    tick();
    tick();
    push("rst_mem_adr", exp_pc);   #1 chk(mem_adr);
    push("rst_op", 32'h0);         chk({26'd0, op});
    push("rst_funct", 32'h0);      chk({26'd0, funct});
    memwrite = 1;
    push("rst_mem_we", 32'h1);     #1 chk({31'd0, mem_we});
    memwrite = 0;
    reset = 1;

    // PC + 4
    alusrca = 0; alusrcb = 2'b01; alucontrol = ALU_ADD; pcsrc = 2'b00; pcen = 1;
    exp_pc = exp_pc + 32'd4;
    push("pc_inc", exp_pc);
    tick();
    idle();
    #1 chk(mem_adr);

    // Fetch lw $8,4($0)
    load_ir(32'h8C08_0004);
    push("fetch_op", {26'd0, ir_m[31:26]});    #1 chk({26'd0, op});
    push("fetch_funct", {26'd0, ir_m[5:0]});   chk({26'd0, funct});
    mem_rd = 32'hFFFF_FFFF;
    tick();
    push("ir_hold_op", {26'd0, ir_m[31:26]});  chk({26'd0, op});
    push("ir_hold_funct", {26'd0, ir_m[5:0]}); chk({26'd0, funct});

    // lw address, memory read, writeback, read-before-write
    alusrca = 1; alusrcb = 2'b10; alucontrol = ALU_ADD;
    tick();
    iord = 1;
    push("lw_adr", 32'd4);                     #1 chk(mem_adr);
    mem_rd = 32'hDEAD_BEEF;
    tick();
    memtoreg = 1; regwrite = 1; regdst = 0;
    tick();
    regwrite = 0;
    push("lw_b_old", 32'h0);                   #1 chk(mem_wd);
    tick();
    push("lw_b_new", 32'hDEAD_BEEF);           chk(mem_wd);
    idle();
    memwrite = 1;
    push("mem_we", 32'h1);                     #1 chk({31'd0, mem_we});
    memwrite = 0;

    // beq compare and branch target
    set_reg(5'd9, 16'd5);
    set_reg(5'd10, 16'd6);
    load_ir(32'h1129_FFFF);
    tick();
    alusrca = 1; alusrcb = 2'b00; alucontrol = ALU_SUB;
    push("beq_eq_zero", 32'h1);                #1 chk({31'd0, zero});
    load_ir(32'h112A_FFFF);
    tick();
    push("beq_ne_zero", 32'h0);                #1 chk({31'd0, zero});
    alusrca = 0; alusrcb = 2'b01; alucontrol = ALU_ADD; pcsrc = 2'b00; pcen = 1;
    tick();
    exp_pc = exp_pc + 32'd4;
    pcen = 0; alusrcb = 2'b11;
    tick();
    simm = {{16{ir_m[15]}}, ir_m[15:0]};
    exp_pc = exp_pc + {simm[29:0], 2'b00};
    pcsrc = 2'b01; pcen = 1;
    tick();
    idle();
    push("beq_target", exp_pc);                #1 chk(mem_adr);

    // R-type ALU operations on A=-1, B=1
    set_reg(5'd11, 16'hFFFF);
    set_reg(5'd12, 16'h0001);
    load_ir(32'h016C_0020);
    tick();
    alusrca = 1; alusrcb = 2'b00; iord = 1;
    for (int k = 0; k < 6; k++) begin
      alucontrol = ctl_tab[k];
      push($sformatf("alu%0d_zero", k), {31'd0, (res_tab[k] == 32'h0)});
      #1 chk({31'd0, zero});
      tick();
      push($sformatf("alu%0d_res", k), res_tab[k]);
      chk(mem_adr);
    end
    alucontrol = ALU_OR;
    tick();
    regwrite = 1; regdst = 1; memtoreg = 0;
    tick();
    idle();
    load_ir(32'h0000_0000);
    tick();
    push("r0_stays_zero", 32'h0);              #1 chk(mem_wd);

    // Build PC = 0x1000_0004 through rf[13] and ALUOut, then jump
    load_ir({OP_LW, 5'd0, 5'd13, 16'h0000});
    mem_rd = 32'h1000_0004;
    tick();
    memtoreg = 1; regwrite = 1; regdst = 0;
    tick();
    idle();
    load_ir(32'h21A0_0000);
    tick();
    alusrca = 1; alusrcb = 2'b10; alucontrol = ALU_ADD;
    tick();
    pcsrc = 2'b01; pcen = 1;
    tick();
    idle();
    exp_pc = 32'h1000_0004;
    push("pc_setup", exp_pc);                  #1 chk(mem_adr);
    load_ir(32'h0800_0010);
    pcsrc = 2'b10; pcen = 1;
    tick();
    idle();
    exp_pc = {exp_pc[31:28], ir_m[25:0], 2'b00};
    push("jump_target", exp_pc);               #1 chk(mem_adr);

    // Reserved pcsrc holds the PC
    pcsrc = 2'b11; pcen = 1;
    tick();
    idle();
    push("pc_hold", exp_pc);                   #1 chk(mem_adr);

    // Jump strobed in a reset cycle is aborted
    pcsrc = 2'b10; pcen = 1; regwrite = 1; reset = 0;
    tick();
    reset = 1;
    idle();
    exp_pc = 32'h0000_0000;
    push("jump_reset_pc", exp_pc);             #1 chk(mem_adr);
    push("jump_reset_op", 32'h0);              chk({26'd0, op});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
